tile_mac_issuer: RTL

TILE_MAC_ISSUER -- requirements
Module: tile_mac_issuer

---
 rtl/tile_pkg.sv | 21 ++
 rtl/tile_product_array.sv | 31 +++
 rtl/tile_mac_issuer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the tile MAC issuer: default widths, accumulator
// mode encoding and the issuer FSM state type.
package tile_pkg;

  localparam int TILE_SIZE_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int BEAT_WIDTH_DEF = 16;

  localparam logic [1:0] MODE_MAC   = 2'b00;
  localparam logic [1:0] MODE_OUTER = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GAP,
    ST_STREAM,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/tile_product_array.sv
// Combinational TILE_SIZE x TILE_SIZE signed product array:
// prod[i][j] = a[i] * W[i][j], full 2*DATA_WIDTH precision.
module tile_product_array
  import tile_pkg::*;
#(
  parameter int TILE_SIZE  = TILE_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]                 op_vec,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0]  op_tile,
  output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][2*DATA_WIDTH-1:0] prod
);

  logic signed [2*DATA_WIDTH-1:0] a_x;
  logic signed [2*DATA_WIDTH-1:0] w_x;

  // Stage p0: operands sign-extended to product width, then multiplied
  always_comb begin
    prod = '0;
    a_x  = '0;
    w_x  = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      for (int j = 0; j < TILE_SIZE; j++) begin
        a_x        = (2*DATA_WIDTH)'($signed(op_vec[i]));
        w_x        = (2*DATA_WIDTH)'($signed(op_tile[i][j]));
        prod[i][j] = a_x * w_x;
      end
    end
  end

endmodule

// File: rtl/tile_mac_issuer.sv
// Tile MAC issuer: accepts a tile command, issues a CLEAR/GAP prologue to the
// reduction accumulator, streams one product matrix per accepted operand beat
// (latency 1) and pulses done aligned with the accumulator's final output.
// Optional build macro TILE_MAC_ISSUER_SKIP_ZERO_EN: in MAC mode an accepted
// beat with an all-zero activation vector is counted but not issued.
module tile_mac_issuer
  import tile_pkg::*;
#(
  parameter int TILE_SIZE  = TILE_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int BEAT_WIDTH = BEAT_WIDTH_DEF
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                cmd_valid,
  output logic                                                cmd_ready,
  input  logic [1:0]                                          cmd_mode,
  input  logic [BEAT_WIDTH-1:0]                               cmd_beats,
  input  logic                                                op_valid,
  output logic                                                op_ready,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]                op_vec,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] op_tile,
  output logic                                                acc_valid,
  output logic [1:0]                                          acc_mode,
  output logic                                                acc_clear,
  output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]  acc_mat,
  output logic                                                busy,
  output logic                                                done
);

  function automatic logic signed [ACC_WIDTH-1:0] sext_acc(
    input logic signed [2*DATA_WIDTH-1:0] p
  );
    return ACC_WIDTH'(p);
  endfunction

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [BEAT_WIDTH-1:0]   beats_q, beats_d;
  logic [BEAT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]              dcnt_q, dcnt_d;
  logic [BEAT_WIDTH:0]     cnt_inc;
  logic                    op_accept;
  logic                    issue_p0;

  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][2*DATA_WIDTH-1:0] prod_p0;
  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]    mat_p0;
  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]    acc_mat_p1;
  logic                                                  vld_p1;

  tile_product_array #(
    .TILE_SIZE  (TILE_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_prod (
    .op_vec  (op_vec),
    .op_tile (op_tile),
    .prod    (prod_p0)
  );

  assign cnt_inc   = {1'b0, cnt_q} + {{BEAT_WIDTH{1'b0}}, 1'b1};
  assign op_accept = op_valid && op_ready;
  assign cmd_ready = rst_n && (state_q == ST_IDLE);

`ifdef TILE_MAC_ISSUER_SKIP_ZERO_EN
  assign issue_p0 = op_accept && !((mode_q == MODE_MAC) && (op_vec == '0));
`else
  assign issue_p0 = op_accept;
`endif

  // Stage p0: widen each product to the accumulator width
  always_comb begin
    mat_p0 = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      for (int j = 0; j < TILE_SIZE; j++) begin
        mat_p0[i][j] = sext_acc(prod_p0[i][j]);
      end
    end
  end

  // FSM state and tile bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MAC;
      beats_q <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // FSM next state and control outputs
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    beats_d   = beats_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    op_ready  = 1'b0;
    acc_clear = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          beats_d = cmd_beats;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        acc_clear = 1'b1;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (beats_q == '0) begin
          // No beats: done lands two cycles after the gap cycle.
          dcnt_d  = 2'd1;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        op_ready = ({1'b0, cnt_q} < {1'b0, beats_q});
        if (op_accept) begin
          cnt_d = cnt_inc[BEAT_WIDTH-1:0];
          if (cnt_inc == {1'b0, beats_q}) begin
            dcnt_d  = 2'd0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == 2'd2) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: registered product matrix and beat valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      acc_mat_p1 <= '0;
    end else begin
      vld_p1 <= issue_p0;
      if (issue_p0) begin
        acc_mat_p1 <= mat_p0;
      end
    end
  end

  assign acc_valid = vld_p1;
  assign acc_mat   = acc_mat_p1;
  assign acc_mode  = mode_q;

endmodule
